// File: rtl/unary_serializer.sv
// unary_serializer: turns an accepted count N into an OUTPUTS-bit unary word with min(N,OUTPUTS) leading ones, sent bit 0 first.
// Latency: out_valid rises the cycle after the input handshake; at full output rate one word every OUTPUTS+1 cycles.
// Backpressure: out_ready low holds index/out_bit/out_last indefinitely; in_ready stays low for the whole word.
module unary_serializer #(
  parameter int OUTPUTS      = 8,
  parameter int COUNTER_BITS = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_in_valid,
  output logic                    o_in_ready,
  input  logic [COUNTER_BITS-1:0] i_count,
  output logic                    o_out_bit,
  output logic                    o_out_valid,
  input  logic                    i_out_ready,
  output logic                    o_out_last,
  output logic [OUTPUTS-1:0]      o_therm,
  output logic                    o_sat
);

  // The count width must be able to represent OUTPUTS itself, so the
  // saturated count and the bit index share one width.
  if ((OUTPUTS < 2) || (OUTPUTS > 16) || ((1 << COUNTER_BITS) <= OUTPUTS)) begin : g_bad_params
    $error("unary_serializer: illegal OUTPUTS/COUNTER_BITS combination");
  end

  localparam logic [COUNTER_BITS-1:0] C_OUTPUTS  = COUNTER_BITS'(OUTPUTS);
  localparam logic [COUNTER_BITS-1:0] C_LAST_IDX = COUNTER_BITS'(OUTPUTS - 1);
  localparam logic [COUNTER_BITS-1:0] C_ONE      = COUNTER_BITS'(1);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } state_e;

  state_e                    r_state;
  state_e                    w_next_state;

  logic [COUNTER_BITS-1:0]   r_idx;
  logic [COUNTER_BITS-1:0]   r_nsat;
  logic [OUTPUTS-1:0]        r_therm;
  logic                      r_sat;
  logic                      r_out_bit;
  logic                      r_out_last;

  logic                      w_in_hs;
  logic                      w_out_hs;
  logic                      w_last_hs;
  logic [COUNTER_BITS-1:0]   w_nsat;
  logic                      w_sat;
  logic [OUTPUTS-1:0]        w_therm;
  logic [COUNTER_BITS-1:0]   w_idx_nxt;

  // Handshake qualifiers; in_ready depends on state only, never on in_valid.
  assign o_in_ready = (r_state == S_IDLE);
  assign w_in_hs    = i_in_valid & o_in_ready;
  assign w_out_hs   = (r_state == S_EMIT) & i_out_ready;
  assign w_last_hs  = w_out_hs & r_out_last;
  assign w_idx_nxt  = r_idx + C_ONE;

  // Saturate the incoming count and build the thermometer word it implies.
  always_comb begin
    w_sat   = (i_count > C_OUTPUTS);
    w_nsat  = w_sat ? C_OUTPUTS : i_count;
    w_therm = '0;
    for (int i = 0; i < OUTPUTS; i++) begin
      w_therm[i] = (COUNTER_BITS'(i) < w_nsat);
    end
  end

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: one word per visit to EMIT, always returning through IDLE.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_in_hs) begin
          w_next_state = S_EMIT;
        end
      end
      S_EMIT: begin
        if (w_last_hs) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Latch the word description on acceptance; therm/sat persist until the next acceptance.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_nsat  <= '0;
      r_therm <= '0;
      r_sat   <= 1'b0;
    end else if (w_in_hs) begin
      r_nsat  <= w_nsat;
      r_therm <= w_therm;
      r_sat   <= w_sat;
    end
  end

  // Bit index and registered serial outputs; everything holds while out_ready is low.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idx      <= '0;
      r_out_bit  <= 1'b0;
      r_out_last <= 1'b0;
    end else if (w_in_hs) begin
      // Index 0 is a one unless the count is zero; OUTPUTS >= 2 so it is never last.
      r_idx      <= '0;
      r_out_bit  <= (w_nsat != '0);
      r_out_last <= 1'b0;
    end else if (w_last_hs) begin
      // Word complete: park the index at 0 instead of wrapping past the last bit.
      r_idx      <= '0;
      r_out_bit  <= 1'b0;
      r_out_last <= 1'b0;
    end else if (w_out_hs) begin
      r_idx      <= w_idx_nxt;
      r_out_bit  <= (w_idx_nxt < r_nsat);
      r_out_last <= (w_idx_nxt == C_LAST_IDX);
    end
  end

  assign o_out_valid = (r_state == S_EMIT);
  assign o_out_bit   = r_out_bit;
  assign o_out_last  = r_out_last;
  assign o_therm     = r_therm;
  assign o_sat       = r_sat;

endmodule

// File: tb/tb_unary_serializer.sv
// Directed bench for unary_serializer with OUTPUTS=8, COUNTER_BITS=4.
// Inputs change and outputs are sampled on the falling clock edge.
// Expected words are written with bit 0 as the first serial bit.
module tb_unary_serializer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] count = '0;
  logic       out_bit;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_last;
  logic [7:0] therm;
  logic       sat;

  logic [15:0] pat;
  int n_total = 0;
  int n_pass  = 0;

  unary_serializer #(.OUTPUTS(8), .COUNTER_BITS(4)) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_count     (count),
    .o_out_bit   (out_bit),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_last  (out_last),
    .o_therm     (therm),
    .o_sat       (sat)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Offer a count and hold it until accepted (bounded wait).
  task automatic send(input logic [3:0] c);
    int t;
    t = 0;
    in_valid = 1'b1;
    count    = c;
    while (!in_ready && t < 50) begin
      step();
      t++;
    end
    chk("send_ready", 32'(in_ready), 32'(1));
    step();
    in_valid = 1'b0;
  endtask

  // Receive one word. mode 0: out_ready always 1; mode 1: out_ready from pattern.
  task automatic collect(input int mode, output logic [7:0] w, output int nhs, output int cyc);
    int   t;
    logic hb, hl, stalled;
    t = 0; nhs = 0; w = '0; stalled = 1'b0; hb = 1'b0; hl = 1'b0;
    chk("latency_valid", 32'(out_valid), 32'(1));
    while (nhs < 8 && t < 200) begin
      out_ready = (mode == 0) ? 1'b1 : pat[t % 16];
      if (out_valid) chk("ready_low_in_emit", 32'(in_ready), 32'(0));
      if (stalled) begin
        chk("stall_valid", 32'(out_valid), 32'(1));
        chk("stall_bit", 32'(out_bit), 32'(hb));
        chk("stall_last", 32'(out_last), 32'(hl));
      end
      if (out_valid && out_ready) begin
        w[nhs] = out_bit;
        chk("last_flag", 32'(out_last), 32'(nhs == 7));
        nhs++;
      end
      stalled = out_valid && !out_ready;
      hb = out_bit;
      hl = out_last;
      step();
      t++;
    end
    out_ready = 1'b0;
    cyc = t;
    chk("idle_after_word", 32'(out_valid), 32'(0));
  endtask

  initial begin
    logic [7:0] w;
    int nhs, cyc;
    pat = 16'b1011_0010_1101_0110;

    // Reset state
    step();
    step();
    chk("rst_valid", 32'(out_valid), 32'(0));
    chk("rst_bit", 32'(out_bit), 32'(0));
    chk("rst_last", 32'(out_last), 32'(0));
    chk("rst_therm", 32'(therm), 32'(0));
    chk("rst_sat", 32'(sat), 32'(0));
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(in_ready), 32'(1));
    @(negedge clk);

    // count=3, full rate
    send(4'd3);
    collect(0, w, nhs, cyc);
    chk("n3_hs", 32'(nhs), 32'(8));
    chk("n3_word", 32'(w), 32'h07);
    chk("n3_cycles", 32'(cyc), 32'(8));
    chk("n3_therm", 32'(therm), 32'h07);
    chk("n3_sat", 32'(sat), 32'(0));
    chk("n3_ready", 32'(in_ready), 32'(1));

    // count=0
    send(4'd0);
    collect(0, w, nhs, cyc);
    chk("n0_word", 32'(w), 32'h00);
    chk("n0_pop", 32'($countones(w)), 32'(0));
    chk("n0_sat", 32'(sat), 32'(0));
    chk("n0_therm", 32'(therm), 32'h00);

    // count=8
    send(4'd8);
    collect(0, w, nhs, cyc);
    chk("n8_word", 32'(w), 32'hFF);
    chk("n8_pop", 32'($countones(w)), 32'(8));
    chk("n8_sat", 32'(sat), 32'(0));

    // count=13 saturates; therm/sat persist through idle
    send(4'd13);
    collect(0, w, nhs, cyc);
    chk("n13_word", 32'(w), 32'hFF);
    chk("n13_therm", 32'(therm), 32'hFF);
    chk("n13_sat", 32'(sat), 32'(1));
    step();
    step();
    step();
    chk("hold_therm", 32'(therm), 32'hFF);
    chk("hold_sat", 32'(sat), 32'(1));

    // count=5 with backpressure
    send(4'd5);
    collect(1, w, nhs, cyc);
    chk("n5_hs", 32'(nhs), 32'(8));
    chk("n5_word", 32'(w), 32'h1F);
    chk("n5_sat", 32'(sat), 32'(0));

    // count=4, then 7 offered during the word
    send(4'd4);
    in_valid = 1'b1;
    count    = 4'd7;
    collect(0, w, nhs, cyc);
    chk("n4_word", 32'(w), 32'h0F);
    chk("n4_therm", 32'(therm), 32'h0F);
    chk("n7_ready_idle", 32'(in_ready), 32'(1));
    step();
    in_valid = 1'b0;
    chk("n7_therm", 32'(therm), 32'h7F);
    collect(0, w, nhs, cyc);
    chk("n7_word", 32'(w), 32'h7F);

    // count=6 aborted by reset after 3 bits
    send(4'd6);
    out_ready = 1'b1;
    step();
    step();
    step();
    chk("n6_bit3", 32'(out_bit), 32'(1));
    chk("n6_valid3", 32'(out_valid), 32'(1));
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_valid", 32'(out_valid), 32'(0));
    chk("abort_bit", 32'(out_bit), 32'(0));
    chk("abort_last", 32'(out_last), 32'(0));
    chk("abort_therm", 32'(therm), 32'h00);
    chk("abort_sat", 32'(sat), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b0;
    #1;
    chk("abort_ready", 32'(in_ready), 32'(1));
    @(negedge clk);
    chk("abort_no_bits", 32'(out_valid), 32'(0));
    send(4'd2);
    collect(0, w, nhs, cyc);
    chk("n2_word", 32'(w), 32'h03);
    chk("n2_hs", 32'(nhs), 32'(8));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
